// File: rtl/eac_result_normalizer_pkg.sv
// Shared datapath constants for the EAC adder and its result normalizer,
// plus the per-stage payload types of the normalizer pipeline.
package eac_result_normalizer_pkg;

  // Carry-lookahead grouping of the EAC adder.
  localparam int CLA_GROUP_WIDTH = 4;
  localparam int ADDER_WIDTH     = 16;
  localparam int CLA_GROUPS      = ADDER_WIDTH / CLA_GROUP_WIDTH;
  localparam int LZC_WIDTH       = $clog2(ADDER_WIDTH + 1);

  typedef logic [ADDER_WIDTH-1:0] mag_t;
  typedef logic [LZC_WIDTH-1:0]   lzc_t;

  typedef struct packed {
    mag_t mag;
    logic flip;
    logic sticky;
  } recover_t;

  typedef struct packed {
    mag_t mag;
    lzc_t lzc;
    logic zero;
    logic flip;
    logic sticky;
  } count_t;

  typedef struct packed {
    mag_t norm_mag;
    lzc_t lzc;
    logic zero;
    logic flip;
    logic sticky;
  } result_t;

endpackage

// File: rtl/eac_result_normalizer_if.sv
// Adder-to-rounding handshake bundle: raw EAC result in, normalized result out.
// slave is the normalizer's view; master is the surrounding datapath's view.
interface eac_result_normalizer_if;
   import eac_result_normalizer_pkg::*;

   logic in_valid;
   logic in_ready;
   mag_t sum;
   logic cout;
   logic effectiveOperation;
   logic sticky;

   logic out_valid;
   logic out_ready;
   mag_t norm_mag;
   lzc_t lzc;
   logic sign_flip;
   logic zero;
   logic sticky_out;

   modport slave (
      input  in_valid, sum, cout, effectiveOperation, sticky, out_ready,
      output in_ready, out_valid, norm_mag, lzc, sign_flip, zero, sticky_out
   );

   modport master (
      output in_valid, sum, cout, effectiveOperation, sticky, out_ready,
      input  in_ready, out_valid, norm_mag, lzc, sign_flip, zero, sticky_out
   );

endinterface

// File: rtl/eac_result_normalizer_lzc_tree.sv
// Combinational leading-zero counter built as a binary tree of (valid, count)
// pairs; all-zero input yields W.
module lzc_tree #(
   parameter int W = 16
) (
   input  logic [W-1:0]             data,
   output logic [$clog2(W+1)-1:0]   count
);

   localparam int L  = $clog2(W);
   localparam int P  = 1 << L;
   localparam int CW = L + 1;
   localparam int OW = $clog2(W + 1);

   logic [P-1:0] padded;

   // Padding with ones below the data makes an all-zero input count exactly W.
   if (P > W) begin : g_pad
      assign padded = {data, {(P - W){1'b1}}};
   end else begin : g_nopad
      assign padded = data;
   end

   for (genvar l = 0; l <= L; l++) begin : g_lvl
      localparam int N = P >> l;
      logic          v [N];
      logic [CW-1:0] c [N];
      for (genvar j = 0; j < N; j++) begin : g_node
         if (l == 0) begin : g_leaf
            assign v[j] = padded[P-1-j];
            assign c[j] = '0;
         end else begin : g_merge
            // An empty upper half contributes its full width to the count.
            assign v[j] = g_lvl[l-1].v[2*j] | g_lvl[l-1].v[2*j+1];
            assign c[j] = g_lvl[l-1].v[2*j] ? g_lvl[l-1].c[2*j]
                                            : (g_lvl[l-1].c[2*j+1] | CW'(1 << (l - 1)));
         end
      end
   end

   assign count = g_lvl[L].v[0] ? OW'(g_lvl[L].c[0]) : OW'(W);

endmodule

// File: rtl/eac_result_normalizer.sv
// Three-stage normalizer behind the EAC adder: recover magnitude, count
// leading zeros, left-normalize; elastic valid/ready pipeline with bubble collapse.
module eac_result_normalizer
   import eac_result_normalizer_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   eac_result_normalizer_if.slave    bus
);

   logic     v1, v2, v3;
   logic     ld1, ld2, ld3;
   logic     complement;
   lzc_t     lzc_cnt;
   mag_t     shifted;
   recover_t s1_d, s1_q;
   count_t   s2_d, s2_q;
   result_t  s3_d, s3_q;

   // A stage loads when empty or when its current content moves on.
   assign ld3 = !v3 || bus.out_ready;
   assign ld2 = !v2 || ld3;
   assign ld1 = !v1 || ld2;

   assign bus.in_ready = ld1;

   // Stage 1: an effective subtraction without end-around carry is negative.
   assign complement = bus.effectiveOperation && !bus.cout;
   assign s1_d = '{mag: complement ? ~bus.sum : bus.sum,
                   flip: complement,
                   sticky: bus.sticky};

   lzc_tree #(.W(ADDER_WIDTH)) u_lzc (
      .data  (s1_q.mag),
      .count (lzc_cnt)
   );

   assign s2_d = '{mag: s1_q.mag,
                   lzc: lzc_cnt,
                   zero: (s1_q.mag == '0),
                   flip: s1_q.flip,
                   sticky: s1_q.sticky};

   // NOTE: every variable written in always_comb gets a value before any
   // conditional update, otherwise a latch is inferred.
   always_comb begin
      shifted = s2_q.mag;
      for (int i = 0; i < LZC_WIDTH; i++) begin
         if (s2_q.lzc[i]) shifted = shifted << (1 << i);
      end
   end

   assign s3_d = '{norm_mag: shifted,
                   lzc: s2_q.lzc,
                   zero: s2_q.zero,
                   flip: s2_q.flip,
                   sticky: s2_q.sticky};

   // NOTE: state is updated with non-blocking assignments so all stages
   // sample their predecessors' old values on the same edge.
   // NOTE: datapath registers are reset too because the outputs must read 0
   // while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         v3   <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         if (ld1) v1 <= bus.in_valid;
         if (ld2) v2 <= v1;
         if (ld3) v3 <= v2;
         if (ld1 && bus.in_valid) s1_q <= s1_d;
         if (ld2 && v1)           s2_q <= s2_d;
         if (ld3 && v2)           s3_q <= s3_d;
      end
   end

   assign bus.out_valid  = v3;
   assign bus.norm_mag   = s3_q.norm_mag;
   assign bus.lzc        = s3_q.lzc;
   assign bus.sign_flip  = s3_q.flip;
   assign bus.zero       = s3_q.zero;
   assign bus.sticky_out = s3_q.sticky;

endmodule

// File: tb/tb_eac_result_normalizer.sv
// Self-checking bench: directed vector table, back-pressure and reset
// sequences, then a randomized stream checked against an arithmetic model.
module tb_eac_result_normalizer;
   import eac_result_normalizer_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   eac_result_normalizer_if bus ();

   eac_result_normalizer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      mag_t sum;
      logic cout;
      logic eop;
      logic sticky;
   } in_t;

   typedef struct {
      mag_t norm;
      lzc_t lzc;
      logic flip;
      logic zero;
      logic sticky;
   } res_t;

   typedef struct {
      in_t  in;
      res_t exp;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: one's-complement magnitude, then count by bit length and scale.
   function automatic res_t model(input in_t x);
      res_t r;
      int   mag;
      int   n;
      mag    = int'(x.sum);
      r.flip = 1'b0;
      if (x.eop && !x.cout) begin
         mag    = ((1 << ADDER_WIDTH) - 1) - int'(x.sum);
         r.flip = 1'b1;
      end
      n = 0;
      while ((mag >> n) != 0) n++;
      r.lzc    = LZC_WIDTH'(ADDER_WIDTH - n);
      r.zero   = (mag == 0);
      r.norm   = ADDER_WIDTH'(mag * (1 << (ADDER_WIDTH - n)));
      r.sticky = x.sticky;
      return r;
   endfunction

   function automatic vec_t mk(input logic [15:0] sum, input logic cout, input logic eop,
                               input logic stk, input logic [15:0] norm, input int lzc,
                               input logic flip, input logic zero, input logic stk_o);
      vec_t v;
      v.in  = '{sum: sum, cout: cout, eop: eop, sticky: stk};
      v.exp = '{norm: norm, lzc: LZC_WIDTH'(lzc), flip: flip, zero: zero, sticky: stk_o};
      return v;
   endfunction

   function automatic in_t rand_in();
      in_t x;
      case ($urandom_range(0, 7))
         0:       x.sum = '1;
         1:       x.sum = '0;
         2:       x.sum = mag_t'($urandom_range(0, 255));
         3:       x.sum = ~mag_t'($urandom_range(0, 255));
         default: x.sum = mag_t'($urandom);
      endcase
      x.cout   = 1'($urandom_range(0, 1));
      x.eop    = 1'($urandom_range(0, 1));
      x.sticky = 1'($urandom_range(0, 1));
      return x;
   endfunction

   task automatic drive(input in_t x);
      bus.sum                = x.sum;
      bus.cout               = x.cout;
      bus.effectiveOperation = x.eop;
      bus.sticky             = x.sticky;
   endtask

   task automatic compare(input string name, input res_t e);
      check({name, ".norm_mag"},   bus.norm_mag,   e.norm);
      check({name, ".lzc"},        bus.lzc,        e.lzc);
      check({name, ".sign_flip"},  bus.sign_flip,  e.flip);
      check({name, ".zero"},       bus.zero,       e.zero);
      check({name, ".sticky_out"}, bus.sticky_out, e.sticky);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] outs();
      return {bus.norm_mag, bus.lzc, bus.sign_flip, bus.zero, bus.sticky_out};
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        tbl [9];
      in_t         items [5];
      res_t        q [$];
      in_t         cur;
      logic [63:0] snap;
      logic        stall_prev;
      logic        hold;
      int          idx;
      int          got;
      int          seen;

      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      drive('{sum: '0, cout: 1'b0, eop: 1'b0, sticky: 1'b0});

      #12 rst_n = 1'b1;
      tick();
      check("reset.out_valid", bus.out_valid, 1'b0);
      check("reset.in_ready",  bus.in_ready,  1'b1);
      compare("reset", '{norm: '0, lzc: '0, flip: 1'b0, zero: 1'b0, sticky: 1'b0});

      // Directed vectors, one at a time with latency checked.
      tbl[0] = mk(16'h0123, 0, 0, 0, 16'h9180,  7, 0, 0, 0);
      tbl[1] = mk(16'hFFF0, 0, 1, 0, 16'hF000, 12, 1, 0, 0);
      tbl[2] = mk(16'h4000, 1, 1, 1, 16'h8000,  1, 0, 0, 1);
      tbl[3] = mk(16'hFFFF, 0, 1, 0, 16'h0000, 16, 1, 1, 0);
      tbl[4] = mk(16'h8001, 0, 0, 1, 16'h8001,  0, 0, 0, 1);
      tbl[5] = mk(16'h00F0, 1, 0, 0, 16'hF000,  8, 0, 0, 0);
      tbl[6] = mk(16'h0000, 0, 0, 0, 16'h0000, 16, 0, 1, 0);
      tbl[7] = mk(16'hFFFE, 0, 1, 1, 16'h8000, 15, 1, 0, 1);
      tbl[8] = mk(16'h7FFF, 0, 1, 0, 16'h8000,  0, 1, 0, 0);

      bus.out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].in);
         bus.in_valid = 1'b1;
         #1 check($sformatf("tbl%0d.in_ready", i), bus.in_ready, 1'b1);
         tick();
         bus.in_valid = 1'b0;
         tick();
         check($sformatf("tbl%0d.early_valid", i), bus.out_valid, 1'b0);
         tick();
         check($sformatf("tbl%0d.out_valid", i), bus.out_valid, 1'b1);
         compare($sformatf("tbl%0d", i), tbl[i].exp);
      end
      tick();
      tick();

      // Back-pressure: five back-to-back items, downstream stalled for 6 cycles.
      for (int k = 0; k < 5; k++) items[k] = rand_in();
      idx = 0;
      got = 0;
      snap = '0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         bus.out_ready = (cyc >= 6);
         bus.in_valid  = (idx < 5);
         if (idx < 5) drive(items[idx]);
         #1;
         if (cyc >= 3 && cyc <= 5) check("bp.in_ready_low", bus.in_ready, 1'b0);
         if (cyc == 3) snap = outs();
         if (cyc == 4 || cyc == 5) begin
            check("bp.hold_valid", bus.out_valid, 1'b1);
            check("bp.hold_data",  outs(),        snap);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (got < 5) compare($sformatf("bp.item%0d", got), model(items[got]));
            got++;
         end
         if (bus.in_valid && bus.in_ready) idx++;
         if (cyc == 5) check("bp.accepted", idx, 3);
         tick();
      end
      bus.in_valid = 1'b0;
      check("bp.count", got, 5);

      // Reset while two items are in flight, one of them presenting at the output.
      tick();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive('{sum: 16'h0F00, cout: 1'b0, eop: 1'b1, sticky: 1'b1});
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < 5 && !bus.out_valid; k++) tick();
      check("rst.pre_valid", bus.out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rst.out_valid", bus.out_valid, 1'b0);
      check("rst.in_ready",  bus.in_ready,  1'b1);
      compare("rst", '{norm: '0, lzc: '0, flip: 1'b0, zero: 1'b0, sticky: 1'b0});
      #3 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.out_valid) seen++;
      end
      check("rst.ghost_items", seen, 0);

      // Randomized stream with random stalls against the model scoreboard.
      stall_prev = 1'b0;
      hold = 1'b0;
      cur = rand_in();
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (!hold) begin
            cur = rand_in();
            bus.in_valid = ($urandom_range(0, 2) != 0);
            drive(cur);
         end
         #1;
         check("rnd.in_ready", bus.in_ready, (q.size() < 3) || bus.out_ready);
         if (stall_prev) check("rnd.hold", {bus.out_valid, outs()}, {1'b1, snap});
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) check("rnd.unexpected_valid", bus.out_valid, 1'b0);
            else compare("rnd", q.pop_front());
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         snap = outs();
         if (bus.in_valid && bus.in_ready) q.push_back(model(cur));
         hold = bus.in_valid && !bus.in_ready;
         tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (bus.out_valid && q.size() != 0) compare("drain", q.pop_front());
         tick();
      end
      check("rnd.drain_left", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eac_result_normalizer.md
Name: eac_result_normalizer

Overview:
- Consumer end of the end-around-carry adder interface in the FMA datapath.
- Takes the raw one's-complement sum, carry-out and operation flags from the EAC adder.
- Recovers the true magnitude: conditional complement when an effective subtraction produced no end-around carry.
- Counts leading zeros and left-normalizes the magnitude for the rounding stage.
- 3-stage pipeline with valid/ready handshakes on both sides.

Parameters:
- ADDER_WIDTH, 16, width of the adder sum and of the normalized output (shared constant, same value as the adder).
- LZC_WIDTH, 5, width of the leading-zero count; equals clog2(ADDER_WIDTH+1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream adder result valid.
- in_ready  output  1  block can accept an input this cycle.
- sum  input  ADDER_WIDTH  raw EAC adder sum.
- cout  input  1  adder end-around carry-out.
- effectiveOperation  input  1  1 = effective subtraction, 0 = effective addition.
- sticky  input  1  sticky bit from alignment; carried alongside the data.
- out_valid  output  1  normalized result valid.
- out_ready  input  1  downstream accepts result.
- norm_mag  output  ADDER_WIDTH  normalized magnitude; MSB = 1 unless zero.
- lzc  output  LZC_WIDTH  left-shift amount applied.
- sign_flip  output  1  result sign must be inverted relative to the product sign.
- zero  output  1  magnitude is exactly zero.
- sticky_out  output  1  sticky aligned with the result.

Behaviour:
- Reset (async, rst_n=0):
  - all stage valid flags clear, so out_valid=0 and in_ready=1 on the first cycle after release.
  - norm_mag, lzc, sign_flip, zero and sticky_out reset to 0.
  - reset mid-operation discards all in-flight items.
- Handshake:
  - transfer occurs when valid & ready are both high.
  - out_valid and the data outputs hold stable while out_valid=1 and out_ready=0.
  - in_ready is combinational from stage-1 valid and downstream advance only; it never depends on in_valid.
- Stage advance rule: stage k loads when stage k is empty or stage k's content moves on this cycle. Bubbles collapse.
  - Capacity is 3 items.
  - Fill throughput is 1/cycle.
  - Latency is 3 cycles from input transfer to out_valid with no stall.
- Stage 1 (recover):
  - if effectiveOperation=1 and cout=0: mag = ~sum, flip = 1.
  - otherwise: mag = sum, flip = 0.
  - sticky registered unchanged.
- Stage 2 (count): lzc = number of leading zeros of mag, range 0..ADDER_WIDTH; zero = (mag == 0).
- Stage 3 (shift): norm_mag = mag << lzc, computed with a logarithmic shifter (LZC_WIDTH levels); shift of ADDER_WIDTH yields 0.
- Boundary cases:
  - Subtraction with sum all ones and cout=0 gives zero=1, lzc=ADDER_WIDTH, norm_mag=0, sign_flip=1. The sign is still reported; the rounding stage applies the zero-sign rule.
  - Addition never complements, regardless of cout. cout on addition is ignored here; the adder already folded it.
  - sum MSB set with no complement gives lzc=0 and a pass-through.
  - Simultaneous input transfer and output transfer in the same cycle with a full pipe is legal; the pipe stays full and no item is lost or duplicated.

Decomposition:
- Shared parameters include: ADDER_WIDTH and LZC_WIDTH go into the existing shared parameters include, next to the CLA group constants.
- Sub-module lzc_tree(parameter W):
  - combinational leading-zero counter built as a binary tree of (valid, count) pairs.
  - instantiated once in stage 2.
  - reusable by the normalizer of the addend path.
- Shifter and complement stay inline.

Test Plan:
1. Addition: effectiveOperation=0, sum=0x0123, cout=0, out_ready=1 -> 3 cycles later out_valid=1, lzc=7, norm_mag=0x9180, sign_flip=0, zero=0.
2. Subtraction, no carry: effectiveOperation=1, sum=0xFFF0, cout=0 -> mag 0x000F, lzc=12, norm_mag=0xF000, sign_flip=1.
3. Subtraction, carry: effectiveOperation=1, sum=0x4000, cout=1, sticky=1 -> lzc=1, norm_mag=0x8000, sign_flip=0, sticky_out=1.
4. Zero: effectiveOperation=1, sum=0xFFFF, cout=0 -> zero=1, lzc=16, norm_mag=0x0000, sign_flip=1.
5. Back-pressure: 5 back-to-back inputs, out_ready=0 for 6 cycles -> in_ready low after 3 transfers, outputs held stable; after out_ready=1 all 5 results emerge in order, none lost or duplicated.
6. Reset mid-flight: 2 items in pipe, pulse rst_n low asynchronously between edges -> out_valid=0 and outputs 0 immediately; neither item appears after release.
